// File: rtl/sirpa_boot_pkg.sv
// rtl/sirpa_boot_pkg.sv - shared state encoding, symbol-per-word helper and enable levels
package sirpa_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } sirpa_boot_state_e;

  localparam logic EN_ON  = 1'b0;
  localparam logic EN_OFF = 1'b1;

  function automatic int sirpa_bpw(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/sirpa_boot_packer.sv
// rtl/sirpa_boot_packer.sv - little-endian symbol-to-word packer with symbol counter
module sirpa_boot_packer
  import sirpa_boot_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  sym_valid_i,
  input  logic [BYTE_WIDTH-1:0] sym_i,
  output logic [DATA_WIDTH-1:0] word_d_o,
  output logic                  word_ready_o
);

  localparam int BPW   = sirpa_bpw(DATA_WIDTH, BYTE_WIDTH);
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [DATA_WIDTH-1:0] shifted;

  // New symbols enter at the top so the first one ends up in the low bits.
  generate
    if (BPW == 1) begin : g_single
      assign shifted = sym_i;
    end else begin : g_multi
      assign shifted = {sym_i, sr_q[DATA_WIDTH-1:BYTE_WIDTH]};
    end
  endgenerate

  // The completed word is exposed in the accepting cycle so the FSM can act on it at once.
  assign word_d_o = shifted;

  always_comb begin
    sr_d         = sr_q;
    cnt_d        = cnt_q;
    word_ready_o = 1'b0;
    if (clear_i) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (sym_valid_i) begin
      sr_d = shifted;
      if (cnt_q == CNT_W'(BPW - 1)) begin
        word_ready_o = 1'b1;
        cnt_d        = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sirpa_boot_arbiter.sv
// rtl/sirpa_boot_arbiter.sv - RAM port owner: boot loader FSM, then core pass-through
module sirpa_boot_arbiter
  import sirpa_boot_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter int          BYTE_WIDTH = 8,
  parameter int unsigned BOOT_BASE  = 0,
  parameter int          MAX_WORDS  = 1024,
  parameter bit          AUTO_BOOT  = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  boot_start_i,
  input  logic [BYTE_WIDTH-1:0] boot_data_i,
  input  logic                  boot_valid_i,
  output logic                  boot_ready_o,
  input  logic [ADDR_WIDTH-1:0] sirpa_add_i,
  input  logic [DATA_WIDTH-1:0] sirpa_datainp_i,
  input  logic                  sirpa_cen_i,
  input  logic                  sirpa_wen_i,
  output logic [DATA_WIDTH-1:0] sirpa_dataout_o,
  output logic                  sirpa_stall_o,
  input  logic [DATA_WIDTH-1:0] ram_dataout_i,
  output logic [ADDR_WIDTH-1:0] control_add_o,
  output logic [DATA_WIDTH-1:0] control_datainp_o,
  output logic                  control_cen_o,
  output logic                  control_wen_o,
  output logic                  boot_busy_o,
  output logic                  boot_done_o,
  output logic                  boot_err_o
);

  localparam int                    CW    = $clog2(MAX_WORDS + 1);
  localparam logic [DATA_WIDTH-1:0] MAX_W = DATA_WIDTH'(MAX_WORDS);

  sirpa_boot_state_e     state_q, state_d;
  logic [CW-1:0]         idx_q, idx_d, nwords_q, nwords_d;
  logic [ADDR_WIDTH-1:0] add_q, add_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  cen_q, cen_d, wen_q, wen_d;
  logic                  busy_q, done_q, err_q;
  logic                  accept, pass, packer_clear, word_ready;
  logic [DATA_WIDTH-1:0] word;

  assign boot_ready_o = (state_q == ST_HDR) || (state_q == ST_LOAD);
  assign accept       = boot_valid_i & boot_ready_o;
  assign packer_clear = !(boot_ready_o || (state_q == ST_WRITE));
  assign pass         = (state_q == ST_DONE);

  sirpa_boot_packer #(
    .DATA_WIDTH(DATA_WIDTH),
    .BYTE_WIDTH(BYTE_WIDTH)
  ) u_packer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (packer_clear),
    .sym_valid_i (accept),
    .sym_i       (boot_data_i),
    .word_d_o    (word),
    .word_ready_o(word_ready)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    nwords_d = nwords_q;
    add_d    = add_q;
    data_d   = data_q;
    cen_d    = EN_OFF;
    wen_d    = EN_OFF;
    case (state_q)
      ST_IDLE: if (AUTO_BOOT || boot_start_i) state_d = ST_HDR;
      ST_HDR: begin
        if (word_ready) begin
          if (word == '0) begin
            state_d = ST_DONE;
          end else if (word > MAX_W) begin
            state_d = ST_ERR;
          end else begin
            idx_d    = '0;
            nwords_d = CW'(word);
            state_d  = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        // Enables are registered, so the write strobe is staged while entering WRITE.
        if (word_ready) begin
          add_d   = ADDR_WIDTH'(BOOT_BASE) + ADDR_WIDTH'(idx_q);
          data_d  = word;
          cen_d   = EN_ON;
          wen_d   = EN_ON;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        idx_d   = idx_q + CW'(1);
        state_d = (idx_d == nwords_q) ? ST_DONE : ST_LOAD;
      end
      ST_DONE, ST_ERR: if (boot_start_i) state_d = ST_HDR;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      nwords_q <= '0;
      add_q    <= '0;
      data_q   <= '0;
      cen_q    <= EN_OFF;
      wen_q    <= EN_OFF;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      nwords_q <= nwords_d;
      add_q    <= add_d;
      data_q   <= data_d;
      cen_q    <= cen_d;
      wen_q    <= wen_d;
      busy_q   <= (state_d == ST_HDR) || (state_d == ST_LOAD) || (state_d == ST_WRITE);
      done_q   <= (state_d == ST_DONE);
      err_q    <= (state_d == ST_ERR);
    end
  end

  assign control_add_o     = pass ? sirpa_add_i     : add_q;
  assign control_datainp_o = pass ? sirpa_datainp_i : data_q;
  assign control_cen_o     = pass ? sirpa_cen_i     : cen_q;
  assign control_wen_o     = pass ? sirpa_wen_i     : wen_q;
  assign sirpa_dataout_o   = pass ? ram_dataout_i   : '0;
  assign sirpa_stall_o     = !pass;
  assign boot_busy_o       = busy_q;
  assign boot_done_o       = done_q;
  assign boot_err_o        = err_q;

endmodule

// File: tb/tb_sirpa_boot_arbiter.sv
// tb/tb_sirpa_boot_arbiter.sv - directed self-checking bench for sirpa_boot_arbiter
module tb_sirpa_boot_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  bdata = '0;
  logic        bvalid = 1'b0;
  logic        bready;
  logic [31:0] s_add = '0, s_din = '0, s_dout, ram_dout = '0;
  logic        s_cen = 1'b1, s_wen = 1'b1, stall;
  logic [31:0] c_add, c_din;
  logic        c_cen, c_wen, busy, done, err;

  int errors = 0;
  int checks = 0;
  int ready_in_write = 0;
  logic [31:0] wr_add[$];
  logic [31:0] wr_dat[$];

  always #5 clk = ~clk;

  sirpa_boot_arbiter dut (
    .clk_i(clk), .rst_i(rst), .boot_start_i(start), .boot_data_i(bdata),
    .boot_valid_i(bvalid), .boot_ready_o(bready), .sirpa_add_i(s_add),
    .sirpa_datainp_i(s_din), .sirpa_cen_i(s_cen), .sirpa_wen_i(s_wen),
    .sirpa_dataout_o(s_dout), .sirpa_stall_o(stall), .ram_dataout_i(ram_dout),
    .control_add_o(c_add), .control_datainp_o(c_din), .control_cen_o(c_cen),
    .control_wen_o(c_wen), .boot_busy_o(busy), .boot_done_o(done), .boot_err_o(err)
  );

  always @(negedge clk) begin
    if (!rst && !done && c_cen === 1'b0 && c_wen === 1'b0) begin
      wr_add.push_back(c_add);
      wr_dat.push_back(c_din);
    end
    if (!rst && bready && c_cen === 1'b0) ready_in_write++;
  end

  task automatic send_sym(input logic [7:0] b, input int gap);
    logic acc;
    bit ok = 0;
    bvalid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bdata = b;
    bvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      acc = bready;
      @(posedge clk); #1;
      if (acc) begin ok = 1; break; end
    end
    bvalid = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL send_timeout got=no_accept exp=accept sym=%0h", b); end
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int i = 0; i < 4; i++)
      send_sym(w[8*i +: 8], (max_gap == 0) ? 0 : int'($urandom_range(1, max_gap)));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic clear_log();
    wr_add.delete();
    wr_dat.delete();
  endtask

  task automatic test_reset();
    s_cen = 1'b0; s_add = 32'h10; ram_dout = 32'hFFFF_0000;
    repeat (2) begin @(posedge clk); #1; end
    checks++; if ({c_cen, c_wen} !== 2'b11) begin errors++; $display("FAIL reset_en got=%b exp=11", {c_cen, c_wen}); end
    checks++; if (c_add !== 32'h0 || c_din !== 32'h0) begin errors++; $display("FAIL reset_addr_data got=%h/%h exp=0/0", c_add, c_din); end
    checks++; if ({stall, busy, done, err, bready} !== 5'b10000) begin errors++; $display("FAIL reset_status got=%b exp=10000", {stall, busy, done, err, bready}); end
    checks++; if (s_dout !== 32'h0) begin errors++; $display("FAIL reset_dout got=%h exp=0", s_dout); end
    s_cen = 1'b1;
    rst = 1'b0;
    checks++; if ({bready, busy} !== 2'b00) begin errors++; $display("FAIL idle_ready got=%b exp=00", {bready, busy}); end
    @(posedge clk); #1;
    checks++; if ({bready, busy, stall} !== 3'b111) begin errors++; $display("FAIL auto_hdr got=%b exp=111", {bready, busy, stall}); end
  endtask

  task automatic test_basic();
    clear_log();
    send_word(32'h0000_0002, 0);
    send_word(32'h4433_2211, 0);
    send_word(32'h8877_6655, 0);
    checks++; if ({c_cen, c_wen, bready, done} !== 4'b0000) begin errors++; $display("FAIL last_write_cycle got=%b exp=0000", {c_cen, c_wen, bready, done}); end
    checks++; if (c_add !== 32'h1 || c_din !== 32'h8877_6655) begin errors++; $display("FAIL last_write_bus got=%h/%h exp=1/88776655", c_add, c_din); end
    @(posedge clk); #1;
    checks++; if ({done, stall, busy} !== 3'b100) begin errors++; $display("FAIL basic_done got=%b exp=100", {done, stall, busy}); end
    checks++; if (wr_add.size() !== 2) begin errors++; $display("FAIL basic_nwrites got=%0d exp=2", wr_add.size()); end
    else begin
      checks++; if (wr_add[0] !== 32'h0 || wr_dat[0] !== 32'h4433_2211) begin errors++; $display("FAIL basic_w0 got=%h@%h exp=44332211@0", wr_dat[0], wr_add[0]); end
      checks++; if (wr_add[1] !== 32'h1 || wr_dat[1] !== 32'h8877_6655) begin errors++; $display("FAIL basic_w1 got=%h@%h exp=88776655@1", wr_dat[1], wr_add[1]); end
    end
  endtask

  task automatic test_passthrough();
    s_add = 32'h1; s_din = 32'h0BAD_F00D; s_cen = 1'b0; s_wen = 1'b1; ram_dout = 32'hCAFE_BABE;
    #1;
    checks++; if (c_add !== 32'h1 || c_din !== 32'h0BAD_F00D) begin errors++; $display("FAIL pass_bus got=%h/%h exp=1/0badf00d", c_add, c_din); end
    checks++; if ({c_cen, c_wen} !== 2'b01) begin errors++; $display("FAIL pass_en got=%b exp=01", {c_cen, c_wen}); end
    checks++; if (s_dout !== 32'hCAFE_BABE) begin errors++; $display("FAIL pass_dout got=%h exp=cafebabe", s_dout); end
    s_cen = 1'b1;
  endtask

  task automatic test_zero_and_blocked();
    clear_log();
    pulse_start();
    checks++; if ({busy, stall, bready, done} !== 4'b1110) begin errors++; $display("FAIL restart_status got=%b exp=1110", {busy, stall, bready, done}); end
    s_cen = 1'b0; s_wen = 1'b0; s_add = 32'h10; ram_dout = 32'h1234_5678;
    #1;
    checks++; if ({c_cen, c_wen} !== 2'b11 || c_add === 32'h10) begin errors++; $display("FAIL blocked_bus got=%b@%h exp=11@not10", {c_cen, c_wen}, c_add); end
    checks++; if (s_dout !== 32'h0) begin errors++; $display("FAIL blocked_dout got=%h exp=0", s_dout); end
    s_cen = 1'b1; s_wen = 1'b1;
    send_word(32'h0, 0);
    checks++; if ({done, stall, busy} !== 3'b100) begin errors++; $display("FAIL zero_done got=%b exp=100", {done, stall, busy}); end
    checks++; if (wr_add.size() !== 0) begin errors++; $display("FAIL zero_nwrites got=%0d exp=0", wr_add.size()); end
  endtask

  task automatic test_err();
    clear_log();
    pulse_start();
    send_word(32'h0000_0401, 0);
    checks++; if ({err, stall, bready, busy, done} !== 5'b11000) begin errors++; $display("FAIL err_status got=%b exp=11000", {err, stall, bready, busy, done}); end
    repeat (3) begin @(posedge clk); #1; end
    checks++; if ({err, stall} !== 2'b11) begin errors++; $display("FAIL err_hold got=%b exp=11", {err, stall}); end
    pulse_start();
    send_word(32'h0000_0001, 0);
    send_word(32'hDEAD_BEEF, 0);
    @(posedge clk); #1;
    checks++; if ({done, err, stall} !== 3'b100) begin errors++; $display("FAIL err_recover got=%b exp=100", {done, err, stall}); end
    checks++; if (wr_add.size() !== 1) begin errors++; $display("FAIL err_nwrites got=%0d exp=1", wr_add.size()); end
    else begin
      checks++; if (wr_add[0] !== 32'h0 || wr_dat[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL err_w0 got=%h@%h exp=deadbeef@0", wr_dat[0], wr_add[0]); end
    end
  endtask

  task automatic test_gaps();
    logic [31:0] words [4];
    words[0] = 32'hA3A2_A1A0; words[1] = 32'h0000_0001;
    words[2] = 32'hFFFF_FFFF; words[3] = 32'h1357_9BDF;
    clear_log();
    ready_in_write = 0;
    pulse_start();
    send_word(32'h0000_0004, 5);
    for (int i = 0; i < 4; i++) send_word(words[i], 5);
    @(posedge clk); #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL gaps_done got=%b exp=1", done); end
    checks++; if (wr_add.size() !== 4) begin errors++; $display("FAIL gaps_nwrites got=%0d exp=4", wr_add.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (wr_add[i] !== 32'(i) || wr_dat[i] !== words[i]) begin errors++; $display("FAIL gaps_w%0d got=%h@%h exp=%h@%h", i, wr_dat[i], wr_add[i], words[i], i); end
      end
    end
    checks++; if (ready_in_write !== 0) begin errors++; $display("FAIL ready_in_write got=%0d exp=0", ready_in_write); end
  endtask

  task automatic test_reset_mid();
    pulse_start();
    send_word(32'h0000_0001, 0);
    send_word(32'h5555_AAAA, 0);
    checks++; if (c_cen !== 1'b0) begin errors++; $display("FAIL midwrite_pre got=%b exp=0", c_cen); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({c_cen, c_wen, bready, stall} !== 4'b1101 || c_add !== 32'h0) begin errors++; $display("FAIL async_rst got=%b@%h exp=1101@0", {c_cen, c_wen, bready, stall}, c_add); end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    send_word(32'h0000_0001, 0);
    send_sym(8'h11, 0); send_sym(8'h22, 0); send_sym(8'h33, 0);
    #2 rst = 1'b1;
    #1;
    checks++; if ({c_cen, c_wen, busy} !== 3'b110) begin errors++; $display("FAIL partial_rst got=%b exp=110", {c_cen, c_wen, busy}); end
    @(posedge clk); #1 rst = 1'b0;
    clear_log();
    @(posedge clk); #1;
    send_word(32'h0000_0001, 0);
    send_word(32'hCAFE_D00D, 0);
    @(posedge clk); #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL post_rst_done got=%b exp=1", done); end
    checks++; if (wr_add.size() !== 1) begin errors++; $display("FAIL post_rst_nwrites got=%0d exp=1", wr_add.size()); end
    else begin
      checks++; if (wr_add[0] !== 32'h0 || wr_dat[0] !== 32'hCAFE_D00D) begin errors++; $display("FAIL post_rst_w0 got=%h@%h exp=cafed00d@0", wr_dat[0], wr_add[0]); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_passthrough();
    test_zero_and_blocked();
    test_err();
    test_gaps();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sirpa_boot_arbiter.md
# sirpa_boot_arbiter

Owns the single RAM port shared by the SiRPA core and the bootstrap loader. After reset it receives a byte stream (header word plus payload words) from the boot link, packs it into RAM words and writes them from a fixed base address, holding the core stalled. Once boot completes, the core's RAM requests pass straight through to the RAM. It supersedes the fixed-width boot/core address mux with a parametrised datapath, a boot FSM and error reporting.

## Interface
- ADDR_WIDTH, 32, RAM word address width
- DATA_WIDTH, 32, RAM word width; must be an integer multiple of BYTE_WIDTH
- BYTE_WIDTH, 8, boot stream symbol width
- BOOT_BASE, 0, first RAM word address written by boot
- MAX_WORDS, 1024, largest accepted payload word count
- AUTO_BOOT, 1, 1 = boot starts right after reset; 0 = wait for boot_start_i

- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- boot_start_i  in  1  one-cycle start/restart request
- boot_data_i  in  BYTE_WIDTH  stream symbol
- boot_valid_i  in  1  symbol valid
- boot_ready_o  out  1  symbol accepted when valid & ready
- sirpa_add_i  in  ADDR_WIDTH  core address
- sirpa_datainp_i  in  DATA_WIDTH  core write data
- sirpa_cen_i  in  1  core chip enable, active-low
- sirpa_wen_i  in  1  core write enable, active-low
- sirpa_dataout_o  out  DATA_WIDTH  read data to core
- sirpa_stall_o  out  1  core must hold its request
- ram_dataout_i  in  DATA_WIDTH  RAM read data
- control_add_o  out  ADDR_WIDTH  RAM address
- control_datainp_o  out  DATA_WIDTH  RAM write data
- control_cen_o  out  1  RAM chip enable, active-low
- control_wen_o  out  1  RAM write enable, active-low
- boot_busy_o, boot_done_o, boot_err_o  out  1 each  status

## Operation
- BPW = DATA_WIDTH/BYTE_WIDTH. Symbols are packed little-endian: first symbol goes to bits [BYTE_WIDTH-1:0].
- States: IDLE, HDR, LOAD, WRITE, DONE, ERR.
- IDLE: go to HDR if AUTO_BOOT (first cycle after reset) or on boot_start_i.
- HDR: assemble one word = count N. If N == 0 go to DONE. If N > MAX_WORDS go to ERR. Otherwise clear idx and go to LOAD.
- LOAD: assemble BPW symbols, then go to WRITE.
- WRITE: one cycle with control_add_o = BOOT_BASE + idx (mod 2^ADDR_WIDTH), control_datainp_o = packed word, cen = 0, wen = 0. Then idx+1; go to DONE if idx+1 == N, else go to LOAD.
- DONE/ERR: boot_start_i restarts at HDR; otherwise the state holds.
- boot_ready_o = 1 only in HDR/LOAD.
- Boot mode (every state except DONE):
  - sirpa_stall_o = 1.
  - RAM outputs are driven from registers; cen = wen = 1 outside WRITE.
  - Core requests are ignored, not queued.
  - sirpa_dataout_o = 0.
- DONE:
  - sirpa_stall_o = 0.
  - control_* follow sirpa_* combinationally.
  - sirpa_dataout_o = ram_dataout_i.
- ERR is a boot mode state, so the core stays stalled.
- boot_busy_o = HDR|LOAD|WRITE; boot_done_o = DONE; boot_err_o = ERR. All are registered.
- boot_start_i during HDR/LOAD/WRITE is ignored.

## Timing
- Reset values:
  - state IDLE; idx, symbol counter and shift register all 0.
  - boot_ready_o 0; control_cen_o 1, control_wen_o 1; control_add_o 0, control_datainp_o 0.
  - sirpa_stall_o 1; all status outputs 0; sirpa_dataout_o 0.
- Reset may assert at any cycle, including mid-WRITE. cen/wen go to 1 asynchronously and any partial word is discarded.
- With AUTO_BOOT=1: IDLE→HDR in the first clock after reset deassertion; boot_ready_o is 1 from the second edge.
- A symbol accepted on edge k in the BPW-th position puts WRITE on cycle k+1. The next symbol can be accepted no earlier than cycle k+2.
- Minimum boot time: (N+1)·BPW + N cycles after entering HDR. Gaps in valid only stretch this.
- DONE is entered on the edge ending the last WRITE. The pass-through is active in the following cycle.

## Structure
- Shared package sirpa_boot_pkg holds:
  - the state enum and its encoding;
  - the BPW derivation helper;
  - constants for the active-low enable levels (EN_ON = 0, EN_OFF = 1).
- Sub-module sirpa_boot_packer handles symbol shift-in, the symbol counter and the word_ready pulse. Its parameters are DATA_WIDTH and BYTE_WIDTH, and it has a clear input driven by the FSM.

## Test plan
- Defaults, AUTO_BOOT=1, stream 02 00 00 00, 11 22 33 44, 55 66 77 88 → writes 0x44332211 @0, then 0x88776655 @1, each with cen = wen = 0 for exactly one cycle. boot_done_o rises after the second write; stall drops.
- Header N=0 → no RAM write, DONE directly, stall 0.
- Header N=MAX_WORDS+1 (0x401) → ERR, boot_err_o=1, no writes, stall stays 1. Then boot_start_i plus a valid N=1 stream → DONE.
- Random valid gaps (1–5 idle cycles) with N=4 → same RAM contents and order. ready never 1 in WRITE.
- During boot, core drives cen=0 at address 0x10 → no RAM access, sirpa_dataout_o=0. After DONE, core read of 0x1 returns ram_dataout_i unchanged.
- rst_i pulsed after 3 symbols of payload word 1 → cen=1 at once. After release, a full N=1 stream writes its word to BOOT_BASE only.
